// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue arbiter slice.
// Contents:
//   ALU_XLEN     datapath width (64 only)
//   alu_op_e     4-bit ALU operation codes
//   buf_state_e  output buffer occupancy states
//   is_legal_op  legality of a control code for full-width / word ops
package alu_pkg;

  localparam int ALU_XLEN = 64;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1111
  } alu_op_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Word (W) variants only exist for add/sub and the three shifts.
  function automatic logic is_legal_op(input logic [3:0] control, input logic is_word);
    logic legal;
    case (control)
      OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA: legal = 1'b1;
      OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU: legal = ~is_word;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 64-bit integer ALU.
// Ports:
//   src1, src2  operands
//   control     alu_op_e code
//   is_word     word variant: only result[31:0] is meaningful, upper half zero
//   result      raw result; unknown/illegal codes give zero
// Sign-extension of word results is done by the caller.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_XLEN-1:0] src1,
  input  logic [ALU_XLEN-1:0] src2,
  input  logic [3:0]          control,
  input  logic                is_word,
  output logic [ALU_XLEN-1:0] result
);

  logic [31:0] w_add_s;
  logic [31:0] w_sub_s;
  logic [31:0] w_sll_s;
  logic [31:0] w_srl_s;
  logic [31:0] w_sra_s;

  // Word-variant intermediates on the low 32 bits, shift amount src2[4:0].
  always_comb begin
    w_add_s = src1[31:0] + src2[31:0];
    w_sub_s = src1[31:0] - src2[31:0];
    w_sll_s = src1[31:0] << src2[4:0];
    w_srl_s = src1[31:0] >> src2[4:0];
    w_sra_s = $signed(src1[31:0]) >>> src2[4:0];
  end

  // Operation select; every unlisted combination yields zero, never X.
  always_comb begin
    result = '0;
    if (is_word) begin
      case (control)
        OP_ADD:  result = {32'h0000_0000, w_add_s};
        OP_SUB:  result = {32'h0000_0000, w_sub_s};
        OP_SLL:  result = {32'h0000_0000, w_sll_s};
        OP_SRL:  result = {32'h0000_0000, w_srl_s};
        OP_SRA:  result = {32'h0000_0000, w_sra_s};
        default: result = '0;
      endcase
    end else begin
      case (control)
        OP_ADD:  result = src1 + src2;
        OP_SUB:  result = src1 - src2;
        OP_AND:  result = src1 & src2;
        OP_OR:   result = src1 | src2;
        OP_XOR:  result = src1 ^ src2;
        OP_SLL:  result = src1 << src2[5:0];
        OP_SRL:  result = src1 >> src2[5:0];
        OP_SRA:  result = $signed(src1) >>> src2[5:0];
        OP_SLT:  result = {63'd0, ($signed(src1) < $signed(src2))};
        OP_SLTU: result = {63'd0, (src1 < src2)};
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req  NREQ-bit request vector
//   ptr  index of the highest-priority requester this cycle
//   gnt  one-hot grant: first set req bit at or above ptr, wrapping
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  // Scan requesters starting at ptr; the first hit wins and masks the rest.
  always_comb begin
    logic found;
    logic hit;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    hit   = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx      = (int'(ptr) + k) % NREQ;
      hit      = req[idx] & ~found;
      gnt[idx] = gnt[idx] | hit;
      found    = found | hit;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared 64-bit ALU with a one-entry,
// requester-tagged result buffer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      per-requester op pending
//   req_ready      one-hot grant (combinational); op transfers on valid&ready
//   req_src1/2     packed operands, requester i at slice i
//   req_control    packed 4-bit op codes
//   req_is_word    per-requester word-variant select
//   req_tag        packed opaque tags
//   rsp_valid      one-hot owner of the buffered result
//   rsp_ready      per-requester result accept (only the owner's bit matters)
//   rsp_result     buffered result (sign-extended for word ops, 0 if illegal)
//   rsp_tag        tag of the buffered op
//   rsp_err        buffered op had an illegal control code
//   busy_cnt       saturating count of FULL cycles that did not drain
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREQ = 2,
  parameter int TAGW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_src1,
  input  logic [NREQ*XLEN-1:0] req_src2,
  input  logic [NREQ*4-1:0]    req_control,
  input  logic [NREQ-1:0]      req_is_word,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 rsp_err,
  output logic [15:0]          busy_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  buf_state_e       state_r;
  logic [PW-1:0]    ptr_r;
  logic [NREQ-1:0]  rsp_valid_r;
  logic [XLEN-1:0]  rsp_result_r;
  logic [TAGW-1:0]  rsp_tag_r;
  logic             rsp_err_r;
  logic [15:0]      busy_cnt_r;

  logic [NREQ-1:0]  arb_gnt_s;
  logic [NREQ-1:0]  gnt_s;
  logic             any_gnt_s;
  logic [PW-1:0]    gnt_idx_s;
  logic [PW-1:0]    next_ptr_s;
  logic             drain_s;
  logic             can_accept_s;
  logic [XLEN-1:0]  alu_src1_s;
  logic [XLEN-1:0]  alu_src2_s;
  logic [3:0]       alu_control_s;
  logic             alu_is_word_s;
  logic [TAGW-1:0]  gnt_tag_s;
  logic [XLEN-1:0]  alu_result_s;
  logic [XLEN-1:0]  ext_result_s;
  logic             legal_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req  (req_valid),
    .ptr  (ptr_r),
    .gnt  (arb_gnt_s)
  );

  // Drain uses only the owner's rsp_ready; the grant is masked while in reset.
  always_comb begin
    drain_s      = (state_r == BUF_FULL) && (|(rsp_valid_r & rsp_ready));
    can_accept_s = (state_r == BUF_EMPTY) || drain_s;
    if (can_accept_s && rst_n) begin
      gnt_s = arb_gnt_s;
    end else begin
      gnt_s = '0;
    end
    any_gnt_s = |gnt_s;
  end

  // Encode the arbiter's one-hot into an index for the operand mux and pointer.
  always_comb begin
    gnt_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_idx_s = gnt_idx_s | (arb_gnt_s[i] ? PW'(i) : '0);
    end
    if (gnt_idx_s == PW'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_s + PW'(1);
    end
  end

  // Operand mux from the winning requester's packed slices.
  always_comb begin
    alu_src1_s    = req_src1[int'(gnt_idx_s)*XLEN +: XLEN];
    alu_src2_s    = req_src2[int'(gnt_idx_s)*XLEN +: XLEN];
    alu_control_s = req_control[int'(gnt_idx_s)*4 +: 4];
    alu_is_word_s = req_is_word[gnt_idx_s];
    gnt_tag_s     = req_tag[int'(gnt_idx_s)*TAGW +: TAGW];
  end

  alu u_alu (
    .src1    (alu_src1_s),
    .src2    (alu_src2_s),
    .control (alu_control_s),
    .is_word (alu_is_word_s),
    .result  (alu_result_s)
  );

  // Word results are sign-extended from bit 31; illegal ops buffer zero.
  always_comb begin
    legal_s = is_legal_op(alu_control_s, alu_is_word_s);
    if (!legal_s) begin
      ext_result_s = '0;
    end else if (alu_is_word_s) begin
      ext_result_s = {{(XLEN-32){alu_result_s[31]}}, alu_result_s[31:0]};
    end else begin
      ext_result_s = alu_result_s;
    end
  end

  // Result buffer FSM and round-robin pointer; a grant always (re)loads FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= BUF_EMPTY;
      ptr_r        <= '0;
      rsp_valid_r  <= '0;
      rsp_result_r <= '0;
      rsp_tag_r    <= '0;
      rsp_err_r    <= 1'b0;
    end else if (any_gnt_s) begin
      state_r      <= BUF_FULL;
      ptr_r        <= next_ptr_s;
      rsp_valid_r  <= gnt_s;
      rsp_result_r <= ext_result_s;
      rsp_tag_r    <= gnt_tag_s;
      rsp_err_r    <= ~legal_s;
    end else if (drain_s) begin
      state_r     <= BUF_EMPTY;
      rsp_valid_r <= '0;
    end else begin
      state_r     <= state_r;
      rsp_valid_r <= rsp_valid_r;
    end
  end

  // Saturating count of cycles the buffer stayed FULL without draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_r <= 16'd0;
    end else if ((state_r == BUF_FULL) && !drain_s && (busy_cnt_r != 16'hFFFF)) begin
      busy_cnt_r <= busy_cnt_r + 16'd1;
    end else begin
      busy_cnt_r <= busy_cnt_r;
    end
  end

  assign req_ready  = gnt_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_tag    = rsp_tag_r;
  assign rsp_err    = rsp_err_r;
  assign busy_cnt   = busy_cnt_r;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;

  localparam int XLEN = 64;
  localparam int NREQ = 2;
  localparam int TAGW = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_src1;
  logic [NREQ*XLEN-1:0] req_src2;
  logic [NREQ*4-1:0]    req_control;
  logic [NREQ-1:0]      req_is_word;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [XLEN-1:0]      rsp_result;
  logic [TAGW-1:0]      rsp_tag;
  logic                 rsp_err;
  logic [15:0]          busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_full;
  int          m_owner;
  logic [63:0] m_res;
  logic [3:0]  m_tag;
  bit          m_err;
  int          m_ptr;
  int          m_busy;

  alu_issue_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .req_control (req_control),
    .req_is_word (req_is_word),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_tag     (rsp_tag),
    .rsp_err     (rsp_err),
    .busy_cnt    (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the op table.
  task automatic ref_alu(input logic [3:0] c, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] r, output bit e);
    logic [31:0] t;
    e = 0; r = 64'd0; t = 32'd0;
    if (!w) begin
      case (c)
        4'b0000: r = a + b;
        4'b0001: r = a - b;
        4'b0110: r = a ^ b;
        4'b0011: r = a | b;
        4'b0010: r = a & b;
        4'b0100: r = a << b[5:0];
        4'b0111: r = a >> b[5:0];
        4'b1111: r = $signed(a) >>> b[5:0];
        4'b0101: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        4'b1000: r = (a < b) ? 64'd1 : 64'd0;
        default: e = 1;
      endcase
    end else begin
      case (c)
        4'b0000: t = a[31:0] + b[31:0];
        4'b0001: t = a[31:0] - b[31:0];
        4'b0100: t = a[31:0] << b[4:0];
        4'b0111: t = a[31:0] >> b[4:0];
        4'b1111: t = $signed(a[31:0]) >>> b[4:0];
        default: e = 1;
      endcase
      r = e ? 64'd0 : {{32{t[31]}}, t};
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] c, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    req_src1[i*XLEN +: XLEN] = a;
    req_src2[i*XLEN +: XLEN] = b;
    req_control[i*4 +: 4]    = c;
    req_is_word[i]           = w;
    req_tag[i*TAGW +: TAGW]  = t;
  endtask

  task automatic model_reset();
    m_full = 0; m_owner = 0; m_res = 64'd0; m_tag = 4'd0; m_err = 0; m_ptr = 0; m_busy = 0;
  endtask

  // One clock: compare DUT with the model, advance the model, cross the edge.
  task automatic cycle();
    int g;
    bit drn;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rv;
    logic [63:0] r;
    bit e;
    #1;
    exp_rv  = m_full ? (NREQ'(1) << m_owner) : '0;
    drn     = m_full && rsp_ready[m_owner];
    g       = -1;
    if (!m_full || drn) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_tag", 64'(rsp_tag), 64'(m_tag));
    chk("rsp_err", 64'(rsp_err), 64'(m_err));
    chk("busy_cnt", 64'(busy_cnt), 64'(m_busy));
    if (m_full && !drn && m_busy < 65535) m_busy++;
    if (g >= 0) begin
      ref_alu(req_control[g*4 +: 4], req_is_word[g], req_src1[g*XLEN +: XLEN],
              req_src2[g*XLEN +: XLEN], r, e);
      m_full = 1; m_owner = g; m_res = r; m_err = e;
      m_tag = req_tag[g*TAGW +: TAGW];
      m_ptr = (g + 1) % NREQ;
    end else if (drn) begin
      m_full = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [63:0] edge_vals [6];

  initial begin
    edge_vals[0] = 64'd0;
    edge_vals[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    edge_vals[2] = 64'h8000_0000_0000_0000;
    edge_vals[3] = 64'h0000_0000_7FFF_FFFF;
    edge_vals[4] = 64'h0000_0000_8000_0000;
    edge_vals[5] = 64'd63;

    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_src1 = '0; req_src2 = '0; req_control = '0; req_is_word = '0; req_tag = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    chk("reset_busy", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
    cycle();

    // 1: single op
    set_op(0, 4'b0000, 1'b0, 64'd5, 64'd7, 4'd3);
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1;
    chk("t1_grant", 64'(req_ready), 64'd1);
    cycle();
    req_valid = 2'b00;
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_result", rsp_result, 64'd12);
    chk("t1_tag", 64'(rsp_tag), 64'd3);
    chk("t1_err", 64'(rsp_err), 64'd0);
    cycle();

    // 2: contention, pointer now 1
    set_op(1, 4'b0001, 1'b0, 64'd100, 64'd1, 4'd9);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_alternate", 64'(req_ready), (i % 2 == 0) ? 64'd2 : 64'd1);
      cycle();
    end
    req_valid = 2'b00;
    cycle();

    // 3: backpressure and busy_cnt saturation
    req_valid = 2'b11; rsp_ready = 2'b00;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_busy3", 64'(busy_cnt), 64'd3);
    chk("t3_held_tag", 64'(rsp_tag), 64'd9);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    m_busy = 65535;
    #1;
    chk("t3_busy_sat", 64'(busy_cnt), 64'hFFFF);
    rsp_ready = 2'b01;
    cycle();
    rsp_ready = 2'b10;
    #1;
    chk("t3_drain_grant", 64'(req_ready), 64'd1);
    cycle();

    // 4: word sign-extension
    rsp_ready = 2'b11; req_valid = 2'b01;
    set_op(0, 4'b0000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 4'd5);
    cycle();
    chk("t4_addw", rsp_result, 64'hFFFF_FFFF_8000_0000);
    set_op(0, 4'b1111, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 4'd6);
    cycle();
    chk("t4_sraw", rsp_result, 64'hFFFF_FFFF_F800_0000);

    // 5: illegal code then a legal op
    set_op(0, 4'b0110, 1'b1, 64'd3, 64'd5, 4'd7);
    cycle();
    chk("t5_err", 64'(rsp_err), 64'd1);
    chk("t5_zero", rsp_result, 64'd0);
    set_op(0, 4'b0000, 1'b0, 64'd2, 64'd3, 4'd8);
    cycle();
    chk("t5_next_err", 64'(rsp_err), 64'd0);
    chk("t5_next_res", rsp_result, 64'd5);

    // 6: asynchronous reset while FULL
    req_valid = 2'b00; rsp_ready = 2'b00;
    cycle();
    #2;
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_no_grant", 64'(req_ready), 64'd0);
    chk("t6_result", rsp_result, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 2'b11;
    #1;
    chk("t6_first_grant", 64'(req_ready), 64'd1);
    cycle();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom_range(0, 3));
      rsp_ready = NREQ'($urandom_range(0, 3));
      for (int i = 0; i < NREQ; i++) begin
        set_op(i, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : {$urandom, $urandom},
               4'($urandom_range(0, 15)));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
